// File: rtl/board_tx_pkg.sv
// Shared definitions for the board display transmit path.
package board_tx_pkg;

  // Default string capacity, also used by board_to_string.
  localparam int BOARD_NBYTES = 625;

  // String terminator.
  localparam logic [7:0] NUL = 8'h00;

  // Sequencer states
  // state        | meaning
  // ST_IDLE      | waiting for i_start
  // ST_CHECK     | decide: send top byte or finish
  // ST_WAIT_ACK  | strobe issued, waiting for UART busy to rise
  // ST_WAIT_IDLE | UART sending, waiting for busy to fall
  // ST_DONE      | one-cycle frame-complete pulse
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DONE      = 3'd4
  } tx_state_e;

endpackage

// File: rtl/board_tx_sequencer.sv
// Feeds a snapshot of the rendered board string to the UART transmitter one
// byte at a time, stopping at the first NUL or after NBYTES bytes.
module board_tx_sequencer
  import board_tx_pkg::*;
#(
  parameter int NBYTES = BOARD_NBYTES,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [8*NBYTES-1:0] i_string,
  input  logic              i_tx_busy,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_stb,
  output logic              o_busy,
  output logic              o_done
);

  localparam int              SW      = 8 * NBYTES;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES);

  tx_state_e        state_q;
  logic [SW-1:0]    shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       data_q;
  logic             stb_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       top_byte;

  // The next character is always the top byte; shifting avoids a wide index mux.
  assign top_byte = shift_q[SW-1 -: 8];

  // Sequencer FSM with registered outputs; strobe and done default low so
  // each is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            shift_q <= i_string;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((cnt_q == CNT_MAX) || (top_byte == NUL)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            data_q  <= top_byte;
            stb_q   <= 1'b1;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_tx_busy) state_q <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (!i_tx_busy) begin
            shift_q <= {shift_q[SW-9:0], NUL};
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_CHECK;
          end
        end
        ST_DONE: begin
          // i_start deliberately not looked at here: no retrigger from DONE.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data = data_q;
  assign o_tx_stb  = stb_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: doc/board_tx_sequencer.md
# board_tx_sequencer

Sequences the UART transmitter for the 2048 board display. On a start strobe it snapshots the rendered board string and feeds it to `uart_top` one byte at a time over the `i_tx_stb`/`o_tx_busy` handshake. It stops at the first NUL byte or after `NBYTES` bytes. It sits between `board_to_string` and `uart_top`, replacing the direct button-to-strobe connection.

## Interface
- `NBYTES`, 625, string capacity in bytes (string width is 8*NBYTES bits).
- `CNT_W`, 10, byte-counter width; must satisfy 2**CNT_W > NBYTES.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request to transmit the current string; level-sampled each cycle.
- `i_string`  in  8*NBYTES  packed string; byte 0 is bits [8*NBYTES-1 -: 8], so the first character is MSB-first, as in Verilog string literals.
- `i_tx_busy`  in  1  busy flag from `uart_top`.
- `o_tx_data`  out  8  byte presented to `uart_top`.
- `o_tx_stb`  out  1  one-cycle transmit strobe to `uart_top`.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: state IDLE, `o_tx_data`=0x00, `o_tx_stb`=0, `o_busy`=0, `o_done`=0, count=0, shift register all zeros.
- Reset asserted mid-frame aborts the frame immediately. No strobe or done pulse is emitted afterwards.
- **IDLE:** on `i_start`=1, load the shift register from `i_string`, clear the count, and go to CHECK. Otherwise stay in IDLE.
- **CHECK:** let the top byte be shift[8*NBYTES-1 -: 8].
  - If count==NBYTES or the top byte is 0x00, go to DONE.
  - Otherwise register `o_tx_data` = top byte, register `o_tx_stb`=1, and go to WAIT_ACK.
- **WAIT_ACK:** `o_tx_stb` returns to 0 after one cycle. Stay until `i_tx_busy`=1, then go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `i_tx_busy`=0. Then shift the register left by 8 (zero fill), increment the count, and go to CHECK.
- **DONE:** `o_done`=1 for exactly this cycle, then go to IDLE.
- `i_start` is ignored outside IDLE, including in DONE, so no frame restart or retrigger is possible.
- The snapshot decouples the frame from later `i_string` changes; a board update mid-frame does not tear the output.
- An empty string (byte 0 = 0x00) gives DONE with zero strobes.
- A full string with no NUL sends exactly NBYTES bytes.
- `o_tx_data` holds its last value between strobes.
- The count saturates logically at NBYTES; it never wraps because CHECK exits first.

## Timing
- Edge k samples `i_start`=1 in IDLE. CHECK occupies cycle k+1. `o_tx_stb` is high during cycle k+2 with `o_tx_data` valid in the same cycle.
- Per byte, the next strobe occurs 2 cycles after the cycle in which `i_tx_busy` is seen low in WAIT_IDLE (one cycle in CHECK, then the strobe cycle).
- End of frame: `o_done` is high 2 cycles after the final `i_tx_busy` falling-edge sample (one cycle in CHECK, then DONE).
- For an empty string, `o_done` is high at cycle k+2.
- `o_busy` rises in cycle k+1 and falls in the cycle after DONE.
- `o_tx_stb` is never asserted while `i_tx_busy`=1, and never in two consecutive cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `board_tx_pkg` holds:
  - the state encoding (IDLE, CHECK, WAIT_ACK, WAIT_IDLE, DONE) as a 3-bit typedef/localparam set;
  - the NUL constant 8'h00;
  - the default NBYTES shared with `board_to_string`.
- Single module; no sub-module is needed. The byte shift register is inline, avoiding a wide index mux.

## Test plan
- Reset mid-frame: with `rst` pulsed low during WAIT_IDLE, the state returns to IDLE with all outputs at reset values, and no strobe appears after release until a new `i_start`.
- "Hi\0": `i_string` top bytes 0x48,0x69,0x00 and a UART model holding busy high for 10 cycles after each strobe, then `i_start` pulsed. Required: exactly 2 strobes with data 0x48 then 0x69, one `o_done` pulse, and the first strobe 2 cycles after start.
- Empty string: top byte 0x00 and `i_start`. Required: no strobe and `o_done` at start+2.
- Full string: NBYTES=4 with data 0x41,0x42,0x43,0x44 and no NUL. Required: 4 strobes in order, then `o_done`.
- Retrigger and tear: `i_start` held high for the whole frame and `i_string` changed after the first strobe. Required: the original bytes are sent, one frame only, and a new frame starts only from IDLE.
- Busy protocol: busy asserted 3 cycles late after a strobe. Required: no second strobe until busy has risen and fallen, and never a strobe while busy=1.
